// File: rtl/dff_shift_bank.sv
// dff_shift_bank
// ---------------------------------------------------------------------------
// WIDTH-bit register with a mode-selected next-state function (hold, load,
// logical/arithmetic shift, rotate, clear), a clock enable and a
// shifts-since-load counter. It can act as a serializer (parallel load, then
// shift out on sout) or as a deserializer (clear, then shift in from sin).
// `done` pulses once when a full word has been shifted.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high; overrides en and mode
//   en         clock enable; when low q and shift_cnt hold and done drops
//   mode       operation select:
//                000 hold, 001 shl, 010 shr logical, 011 rol,
//                100 ror, 101 load, 110 shr arithmetic, 111 clear
//   sin        serial input bit for shl/shr
//   data       parallel load value
//   q          register contents (registered)
//   sout       bit that leaves the register on the next enabled shift edge
//              (combinational from q and mode)
//   shift_cnt  shifts since last load/clear/reset, saturating at WIDTH
//   done       one-cycle pulse after shift_cnt steps WIDTH-1 -> WIDTH
// ---------------------------------------------------------------------------
module dff_shift_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             done_reg;
  logic             done_next;

  // Every shift/rotate is either a move toward the MSB or toward the LSB;
  // only the bit filling the vacated end differs between modes.
  logic move_left;
  logic move_right;
  logic fill_lo;
  logic fill_hi;
  logic do_load;
  logic do_clear;

  assign move_left  = (mode == MODE_SHL) || (mode == MODE_ROL);
  assign move_right = (mode == MODE_SHR) || (mode == MODE_ROR) || (mode == MODE_ASR);
  assign do_load    = (mode == MODE_LOAD);
  assign do_clear   = (mode == MODE_CLR);

  always_comb begin
    fill_lo = sin;
    if (mode == MODE_ROL) begin
      fill_lo = q_reg[WIDTH-1];
    end
  end

  always_comb begin
    fill_hi = sin;
    if (mode == MODE_ROR) begin
      fill_hi = q_reg[0];
    end else if (mode == MODE_ASR) begin
      fill_hi = q_reg[WIDTH-1];
    end
  end

  // Per-bit next-state mux: each bit takes its lower neighbour on a left
  // move, its upper neighbour on a right move, with the end bits taking the
  // mode-dependent fill instead.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic from_lower;
      logic from_upper;

      if (gi == 0) begin : g_lsb
        assign from_lower = fill_lo;
      end else begin : g_lsb_n
        assign from_lower = q_reg[gi-1];
      end

      if (gi == WIDTH - 1) begin : g_msb
        assign from_upper = fill_hi;
      end else begin : g_msb_n
        assign from_upper = q_reg[gi+1];
      end

      assign q_next[gi] = move_left  ? from_lower :
                          move_right ? from_upper :
                          do_load    ? data[gi]   :
                          do_clear   ? 1'b0       :
                                       q_reg[gi];
    end
  endgenerate

  // Counter saturates at WIDTH; done fires only on the single step into
  // saturation, so it re-arms only when the counter is zeroed again.
  always_comb begin
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    if (do_load || do_clear) begin
      cnt_next = '0;
    end else if ((move_left || move_right) && (cnt_reg != CNT_FULL)) begin
      cnt_next  = cnt_reg + CNT_W'(1);
      done_next = (cnt_reg == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg    <= RESET_VAL;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else if (en) begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end else begin
      done_reg <= 1'b0;
    end
  end

  always_comb begin
    sout = 1'b0;
    case (mode)
      MODE_SHL, MODE_ROL:           sout = q_reg[WIDTH-1];
      MODE_SHR, MODE_ROR, MODE_ASR: sout = q_reg[0];
      MODE_HOLD, MODE_LOAD, MODE_CLR: sout = 1'b0;
      default:                      sout = 1'b0;
    endcase
  end

  assign q         = q_reg;
  assign shift_cnt = cnt_reg;
  assign done      = done_reg;

endmodule
